spram_stream_ctrl: RTL and testbench
====================================

# spram_stream_ctrl

Frame-buffer controller placed directly in front of `spram_4096_60bit`; it drives that RAM's address/wren/data inputs and consumes its registered `out`. It accepts a valid/ready word stream, writes one frame sequentially into the RAM, then replays the frame in order on a valid/ready output stream. A 2-entry output buffer hides the RAM's 1-cycle read latency, sustaining one word per cycle under continuous `out_ready`.

## Interface
- AWIDTH, 12, RAM address width
- DWIDTH, 60, word width
- NUM_WORDS, 4096, frame capacity (2^AWIDTH)
- clk  in  1  single clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input word
- in_data  in  DWIDTH  input word
- in_last  in  1  final word of frame
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts output word
- out_data  out  DWIDTH  output word
- out_last  out  1  final word of frame
- ram_address  out  AWIDTH  to RAM `address`
- ram_wren  out  1  to RAM `wren`
- ram_data  out  DWIDTH  to RAM `data`
- ram_out  in  DWIDTH  from RAM `out`, valid the cycle after a read is issued
- busy  out  1  high in DRAIN
- count  out  AWIDTH+1  words stored in the current frame

## Operation
- Reset (resetn=0 at posedge): state=FILL, wr_ptr=0, rd_ptr=0, count=0, buffer empty, in-flight flag=0. Outputs after reset: in_ready=1, out_valid=0, out_last=0, busy=0, ram_wren=0, out_data=0. RAM contents untouched.
- FILL: in_ready=1. Accept = in_valid & in_ready. ram_wren=accept (combinational), ram_address=wr_ptr, ram_data=in_data. On accept: wr_ptr++, count++. If in_last=1 or wr_ptr=NUM_WORDS-1 at accept: len=wr_ptr+1, next state DRAIN.
- DRAIN: in_ready=0, ram_wren=0, ram_address=rd_ptr, busy=1; in_valid ignored.
- Read issue in DRAIN when rd_ptr<len and held+in_flight−pop ≤ 1 (held = buffer entries 0..2, pop = out_valid & out_ready). Issue: rd_ptr++, in_flight=1 for the next cycle; otherwise in_flight=0.
- Cycle after an issue: ram_out is written into the buffer tail, tagged last if its address was len−1.
- Buffer head drives out_data/out_last; out_valid = held>0. Pop and capture in the same cycle are both honoured.
- Pop of the last-tagged word: next cycle state=FILL, wr_ptr=rd_ptr=count=0, buffer empty.
- count holds len throughout DRAIN.
- Handshake: once out_valid=1, out_data and out_last stay stable until popped.

## Timing
- FILL: ram write occurs in the same cycle as accept; one word per cycle max.
- Cycle T = first DRAIN cycle: read of address 0 issued at T. ram_out valid at T+1, captured at end of T+1, so out_valid=1 at T+2.
- With out_ready held high, words leave at T+2 .. T+1+len, one per cycle with no bubbles; out_last at T+1+len; FILL (in_ready=1) at T+2+len.
- Stalls: with out_ready=0, at most 2 words are buffered and no further reads issue. Data is never lost or duplicated.
- Wrap: a full frame (4096 words) ends FILL on the write to address 4095 even with in_last=0; count=4096.
- in_last on the 4096th word: same single transition.
- Reset mid-FILL or mid-DRAIN: the whole frame is abandoned and all reset values apply on the next cycle.

## Test plan
- Frame of 4 words 0xA0..0xA3, last on 0xA3, out_ready=1 → writes at addresses 0..3; outputs 0xA0..0xA3 on 4 consecutive cycles starting T+2; out_last only with 0xA3; in_ready=1 at T+6.
- Single-word frame 0x5 with in_last → count=1; one output 0x5 with out_last=1; return to FILL.
- 10-word frame, out_ready toggling 1,0,0,1,… → exact sequence preserved; out_data stable while stalled; never more than 2 read issues ahead of pops.
- 4096 words (data=address), in_last=0 → DRAIN entered after address 4095; count=4096; 4096 outputs in order; out_last on word 4095.
- in_valid=1 held during DRAIN with junk data → in_ready=0, ram_wren=0, no output corruption.
- resetn=0 for 1 cycle midway through a drain → out_valid=0, in_ready=1, count=0 next cycle; a fresh 2-word frame then replays correctly.

Source files
------------

// File: rtl/spram_stream_ctrl.sv
// Frame buffer in front of a single-port RAM: write one frame in, replay it out.
// A 2-entry skid buffer hides the RAM's registered-read latency.
module spram_stream_ctrl #(
    parameter int AWIDTH    = 12,
    parameter int DWIDTH    = 60,
    parameter int NUM_WORDS = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_wren,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_out,
    output logic              busy,
    output logic [AWIDTH:0]   count
);

    localparam int CW = AWIDTH + 1;

    typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        held_q, held_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              last0_q, last0_d, last1_q, last1_d;

    logic accept, pop, done, wrap, issue, slot1;
    logic [2:0] occ;

    assign accept = in_valid & (state_q == S_FILL);
    assign pop    = (held_q != 2'd0) & out_ready;
    assign done   = pop & last0_q;
    assign wrap   = wr_ptr_q == AWIDTH'(NUM_WORDS - 1);
    // Words buffered or in flight once this cycle's pop leaves.
    assign occ    = {1'b0, held_q} + {2'b0, infl_q} - {2'b0, pop};
    assign issue  = (state_q == S_DRAIN) & (rd_ptr_q < count_q)
                  & (occ <= 3'd1);
    assign slot1  = (held_q - {1'b0, pop}) != 2'd0;

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL:  if (accept && (in_last || wrap)) state_d = S_DRAIN;
            S_DRAIN: if (done) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        ram_wren    = 1'b0;
        busy        = 1'b0;
        ram_address = rd_ptr_q[AWIDTH-1:0];
        unique case (state_q)
            S_FILL: begin
                in_ready    = 1'b1;
                ram_wren    = in_valid;
                ram_address = wr_ptr_q;
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    assign ram_data  = in_data;
    assign out_valid = held_q != 2'd0;
    assign out_data  = buf0_q;
    assign out_last  = last0_q & out_valid;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        infl_d      = issue;
        infl_last_d = issue & (rd_ptr_q == count_q - CW'(1));
        held_d      = held_q - {1'b0, pop} + {1'b0, infl_q};
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
            count_d  = count_q + CW'(1);
        end
        if (issue) rd_ptr_d = rd_ptr_q + CW'(1);
        if (pop) begin
            buf0_d  = buf1_q;
            last0_d = last1_q;
        end
        if (infl_q) begin
            if (slot1) begin
                buf1_d  = ram_out;
                last1_d = infl_last_q;
            end else begin
                buf0_d  = ram_out;
                last0_d = infl_last_q;
            end
        end
        if (done) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            held_d   = '0;
            infl_d   = 1'b0;
            last0_d  = 1'b0;
            last1_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            held_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            held_q      <= held_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

endmodule

// File: tb/tb_spram_stream_ctrl.sv
// Scoreboard bench for spram_stream_ctrl with a behavioural registered-read RAM.
module tb_spram_stream_ctrl;

    localparam int AW = 12;
    localparam int DW = 60;
    localparam int NW = 4096;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW-1:0] ram_address;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_out;
    logic          busy;
    logic [AW:0]   count;

    logic [DW-1:0] mem [NW];
    logic [DW:0]   sb [$];

    int tests;
    int fails;
    int cyc;
    int t_cyc;
    int first_pop;
    bit armed;
    bit stall;
    logic [DW-1:0] stall_d;

    spram_stream_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_out(ram_out),
        .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_out <= mem[ram_address];
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare every handshake against the scoreboard.
    always @(negedge clk) begin
        if (stall && out_valid) chk("stable", 64'(out_data), 64'(stall_d));
        stall   = out_valid && !out_ready;
        stall_d = out_data;
        if (out_valid && out_ready) begin
            if (armed) begin
                first_pop = cyc;
                armed     = 1'b0;
            end
            if (sb.size() == 0) begin
                chk("unexpected", 64'(out_data), 64'hDEAD);
            end else begin
                logic [DW:0] e;
                e = sb.pop_front();
                chk("data", 64'(out_data), 64'(e[DW-1:0]));
                chk("last", 64'(out_last), 64'(e[DW]));
            end
        end
    end

    task automatic send_frame(input int len, input logic [DW-1:0] base,
                              input bit use_last);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            in_last  = use_last && (i == len - 1);
            sb.push_back({i == len - 1, in_data});
            @(negedge clk);
            chk("wren", 64'(ram_wren), 64'd1);
            chk("waddr", 64'(ram_address), 64'(i % NW));
            chk("wdata", 64'(ram_data), 64'(in_data));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        t_cyc    = cyc;
        armed    = 1'b1;
    endtask

    task automatic drain(input int len, input bit pat, input bit junk,
                         input string tag);
        int n;
        n = 0;
        while (!in_ready && n < len * 4 + 20) begin
            out_ready = pat ? (n % 3 == 0) : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end
            @(negedge clk);
            if (n == 0) begin
                chk({tag, "_count"}, 64'(count), 64'(len));
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
            if (junk) begin
                chk("junk_rdy", 64'(in_ready), 64'd0);
                chk("junk_wren", 64'(ram_wren), 64'd0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (n >= len * 4 + 20) chk({tag, "_timeout"}, 64'd0, 64'd1);
        if (!pat) begin
            chk({tag, "_lat"}, 64'(n), 64'(len + 2));
            chk({tag, "_first"}, 64'(first_pop - t_cyc), 64'd2);
        end
        chk({tag, "_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        armed = 1'b0; stall = 1'b0; first_pop = 0; t_cyc = 0;
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_inrdy", 64'(in_ready), 64'd1);
        chk("rst_oval", 64'(out_valid), 64'd0);
        chk("rst_olast", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wren", 64'(ram_wren), 64'd0);
        chk("rst_odata", 64'(out_data), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(posedge clk); #1;

        send_frame(4, DW'(60'hA0), 1'b1);
        drain(4, 1'b0, 1'b0, "f4");

        send_frame(1, DW'(60'h5), 1'b1);
        drain(1, 1'b0, 1'b0, "f1");

        send_frame(10, DW'(60'h100), 1'b1);
        drain(10, 1'b1, 1'b0, "f10");

        send_frame(6, DW'(60'h200), 1'b1);
        drain(6, 1'b0, 1'b1, "junk");

        send_frame(10, DW'(60'h300), 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        resetn    = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mrst_oval", 64'(out_valid), 64'd0);
        chk("mrst_inrdy", 64'(in_ready), 64'd1);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_frame(2, DW'(60'h400), 1'b1);
        drain(2, 1'b0, 1'b0, "f2");

        send_frame(NW, '0, 1'b0);
        drain(NW, 1'b0, 1'b0, "full");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
